life_manager: RTL
=================

LIFE_MANAGER -- requirements
Module: life_manager

Interface
REQ-001 Parameter INIT_LIVES, default 3, lives loaded at game start.
REQ-002 Parameter MAX_LIVES, default 9, saturation ceiling; SHALL be 1..9 so the value fits one decimal digit.
REQ-003 Parameter INVULN_TICKS, default 120, frame ticks of invulnerability after a hit; SHALL be 1..255.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse, begin new game.
REQ-007 hit  input  1  one-cycle pulse, player collision.
REQ-008 bonus  input  1  one-cycle pulse, extra-life pickup.
REQ-009 tick  input  1  one-cycle frame tick (e.g. 60 Hz strobe).
REQ-010 life  output  4  current lives, 0..MAX_LIVES, registered; drives the seven-segment life digit.
REQ-011 game_over  output  1  high while in OVER state.
REQ-012 invuln  output  1  high while in INVULN state.
REQ-013 blink  output  1  display blink hint: bit 3 of the invulnerability counter while invuln, else 0.
REQ-014 life_lost  output  1  one-cycle pulse when a hit decrements life.

Function
REQ-015 FSM states: IDLE, PLAY, INVULN, OVER; all outputs registered, updating the cycle after the sampled input pulse.
REQ-016 start SHALL have priority over all other inputs in every state: life<=INIT_LIVES, counter<=0, state<=PLAY, same-cycle hit/bonus ignored.
REQ-017 IDLE: hit, bonus, tick ignored; life=0.
REQ-018 PLAY, hit only, life>1: life<=life-1, life_lost<=1, counter<=INVULN_TICKS, state<=INVULN.
REQ-019 PLAY, hit only, life==1: life<=0, life_lost<=1, state<=OVER.
REQ-020 PLAY, hit and bonus same cycle: life unchanged, life_lost<=1, counter<=INVULN_TICKS, state<=INVULN (never OVER).
REQ-021 PLAY or INVULN, bonus without counted hit: life<=min(life+1, MAX_LIVES); no wrap at MAX_LIVES.
REQ-022 INVULN: hit ignored (no decrement, no life_lost); bonus per REQ-021.
REQ-023 INVULN: each tick decrements counter by 1; when a tick occurs with counter==1, counter<=0 and state<=PLAY on that edge; exactly INVULN_TICKS ticks spent in INVULN.
REQ-024 tick coincident with the hit that enters INVULN SHALL not decrement the freshly loaded counter.
REQ-025 OVER: hit, bonus, tick ignored; life holds 0; only start or reset exits.
REQ-026 Counter 8 bits, unsigned; SHALL never underflow below 0.
REQ-027 life SHALL never exceed MAX_LIVES nor go below 0 under any input sequence.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, life=0, counter=0, game_over=0, invuln=0, blink=0, life_lost=0, regardless of clk, including mid-INVULN.
REQ-029 After rst_n deasserts, first state change SHALL occur only on a start pulse.

Verification
REQ-030 Reset, start, then hit -> life 3->2, life_lost one cycle, invuln=1; 120 ticks later invuln=0, state PLAY.
REQ-031 Start, hit, 5 more hits during INVULN -> life stays 2, no further life_lost pulses.
REQ-032 Start, three hits each separated by >120 ticks -> life 2,1,0; game_over=1 after third; further hit/bonus/tick leave life=0.
REQ-033 Start, 8 bonus pulses -> life saturates at 9; ninth bonus leaves 9.
REQ-034 life=1 in PLAY, hit and bonus same cycle -> life=1, invuln=1, game_over=0; start and hit same cycle in OVER -> life=3, PLAY, no life_lost.
REQ-035 rst_n asserted asynchronously mid-INVULN with counter=57 -> all outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/life_manager.sv
// Player life counter with a post-hit invulnerability window and game-over detection.
// Every output is registered from the next-state logic, so it changes the cycle after the input pulse.
module life_manager #(
  parameter int INIT_LIVES   = 3,
  parameter int MAX_LIVES    = 9,
  parameter int INVULN_TICKS = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       bonus,
  input  logic       tick,
  output logic [3:0] life,
  output logic       game_over,
  output logic       invuln,
  output logic       blink,
  output logic       life_lost
);

  typedef enum logic [1:0] {IDLE, PLAY, INVULN, OVER} state_t;

  localparam logic [3:0] INIT_L = 4'(INIT_LIVES);
  localparam logic [3:0] MAX_L  = 4'(MAX_LIVES);
  localparam logic [7:0] INV_T  = 8'(INVULN_TICKS);

  state_t     state_q, state_d;
  logic [3:0] life_q, life_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lost_q, lost_d;
  logic       over_q, inv_q, blink_q;

  // Bonus pickups clamp at the ceiling instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= MAX_L) ? MAX_L : v + 4'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    life_d  = life_q;
    cnt_d   = cnt_q;
    lost_d  = 1'b0;
    if (start) begin
      state_d = PLAY;
      life_d  = INIT_L;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: ;
        PLAY: begin
          if (hit) begin
            lost_d = 1'b1;
            if (bonus) begin
              cnt_d   = INV_T;
              state_d = INVULN;
            end else if (life_q > 4'd1) begin
              life_d  = life_q - 4'd1;
              cnt_d   = INV_T;
              state_d = INVULN;
            end else begin
              life_d  = 4'd0;
              state_d = OVER;
            end
          end else if (bonus) begin
            life_d = sat_inc(life_q);
          end
        end
        INVULN: begin
          if (bonus) life_d = sat_inc(life_q);
          // A zero counter here would be corrupt; leave rather than wrap.
          if (tick) begin
            if (cnt_q <= 8'd1) begin
              cnt_d   = 8'd0;
              state_d = PLAY;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        OVER:    life_d = 4'd0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      life_q  <= 4'd0;
      cnt_q   <= 8'd0;
      lost_q  <= 1'b0;
      over_q  <= 1'b0;
      inv_q   <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      life_q  <= life_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      over_q  <= (state_d == OVER);
      inv_q   <= (state_d == INVULN);
      blink_q <= (state_d == INVULN) & cnt_d[3];
    end
  end

  assign life      = life_q;
  assign game_over = over_q;
  assign invuln    = inv_q;
  assign blink     = blink_q;
  assign life_lost = lost_q;

endmodule
